line_buf_1bit_rd_ctrl: RTL and testbench
========================================

// Module: line_buf_1bit_rd_ctrl
// PURPOSE
//  Read-side controller for the 1-bit asynchronous line-buffer FIFO in the HDMI erosion/dilation path.
//  Runs in the display (rd_clk) domain and converts the display pixel request (DE) into FIFO rd_en pulses.
//  Counts pixels and lines against the active frame size and tags line/frame boundaries.
//  Substitutes FILL_VAL and records an underflow whenever data is not available.
// PARAMETERS
//  H_ACTIVE     1280  active pixels per line
//  V_ACTIVE     720   active lines per frame
//  FILL_VAL     1'b0  pixel value emitted on underflow or during prefill
//  PREFILL_EN   1     1: wait for fifo_almost_empty==0 before the first read of a frame; 0: read immediately
//  UFL_CNT_W    16    width of the underflow counter
// PORTS
//  rd_clk            in   1          display pixel clock
//  rd_rst            in   1          reset (already decided): rd_rst, asynchronous, active-high; clock rd_clk
//  frame_start       in   1          single-cycle pulse, start of a new frame (rd_clk synchronous)
//  pix_req           in   1          display wants one pixel this cycle (DE)
//  fifo_rd_en        out  1          FIFO read enable (combinational)
//  fifo_rd_data      in   1          FIFO read data, valid one cycle after fifo_rd_en (no output register)
//  fifo_rd_empty     in   1          FIFO empty
//  fifo_almost_empty in   1          FIFO below its almost-empty threshold
//  pix_out           out  1          output pixel
//  pix_valid         out  1          pix_out valid
//  pix_sol           out  1          qualifies pix_valid: first pixel of a line
//  pix_eol           out  1          qualifies pix_valid: last pixel of a line
//  pix_sof           out  1          qualifies pix_valid: first pixel of the frame
//  underflow         out  1          sticky; cleared by frame_start or rd_rst
//  underflow_cnt     out  UFL_CNT_W  starved pixels this frame; saturates at max; cleared by frame_start
//  busy              out  1          state != IDLE
// BEHAVIOUR
//  Reset values
//  - All outputs are 0. State=IDLE. h_cnt=v_cnt=0.
//  States
//  - IDLE: pix_req is ignored (no pix_valid). frame_start -> PREFILL.
//  - PREFILL: when PREFILL_EN==0 or fifo_almost_empty==0, move to STREAM on the next cycle.
//    A pix_req in PREFILL is a starved pixel.
//  - STREAM: fifo_rd_en = pix_req & ~fifo_rd_empty. A pix_req while empty is a starved pixel.
//  - Every pix_req in PREFILL or STREAM advances h_cnt, served or starved.
//    h_cnt wraps at H_ACTIVE-1 and v_cnt increments on the wrap.
//  - On the last pixel (h_cnt=H_ACTIVE-1 and v_cnt=V_ACTIVE-1), go to IDLE.
//  - frame_start in any state clears counters and flags and goes to PREFILL.
//    This has priority over a simultaneous pix_req; that request is discarded, with no pix_valid and no read.
//  Latency
//  - pix_valid, sol, eol and sof are registered: asserted exactly 1 cycle after the accepted pix_req.
//  - pix_out = fifo_rd_data if the request was served, else FILL_VAL. The select is registered alongside pix_valid.
//  - Starved pixel: pix_valid=1, pix_out=FILL_VAL, underflow<=1, underflow_cnt+1 (saturating).
//    The starved pixel is not made up later; the stream stays pixel-aligned to the display.
//  - fifo_rd_en is never asserted while fifo_rd_empty=1 or outside STREAM.
//  Widths
//  - h_cnt is $clog2(H_ACTIVE) bits; v_cnt is $clog2(V_ACTIVE) bits.
//  - Comparisons use parameter-1 constants.
//  Reset mid-frame
//  - rd_rst asserted at any cycle forces the reset values immediately.
//  - The FIFO content is not flushed by this block; the FIFO shares rd_rst.
// STRUCTURE
//  - Shared package line_buf_pkg: state enum {IDLE, PREFILL, STREAM}, default H/V active constants.
//  - Single flat module; no sub-module needed.
//  - Counters and the FSM live in one always block; outputs come from a registered pipe stage.
// TESTING
//  1 H=8,V=2, FIFO preloaded with 16 bits 1010..., frame_start, then 16 pix_req
//    -> 16 pix_valid, pattern 1010..., sol at pixels 0 and 8, eol at 7 and 15, sof at 0 only, then busy=0.
//  2 FIFO empties after 5 pixels of an 8-pixel line
//    -> pixels 5..7 = FILL_VAL, underflow=1, underflow_cnt=3, fifo_rd_en=0 while empty.
//  3 PREFILL_EN=1, almost_empty held 1 for 10 cycles with 3 pix_req
//    -> 3 FILL_VAL pixels, no rd_en; STREAM entered 1 cycle after almost_empty falls.
//  4 frame_start coincides with pix_req at h_cnt=4
//    -> no pix_valid for that request; counters=0; underflow/underflow_cnt cleared.
//  5 rd_rst pulsed mid-line
//    -> all outputs 0 the same cycle, state IDLE; a following pix_req gives no pix_valid until frame_start.
//  6 UFL_CNT_W=2, 6 starved pixels -> underflow_cnt saturates at 3.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared definitions for the 1-bit line-buffer read path:
// the read-controller state type and the default active frame size.
package line_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        STREAM
    } rd_state_e;

    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_V_ACTIVE = 720;

endpackage

// File: rtl/line_buf_1bit_rd_ctrl.sv
// Display-side read controller for the 1-bit line-buffer FIFO: turns DE into FIFO reads,
// tags line/frame boundaries and substitutes a fill value when data is not available.
module line_buf_1bit_rd_ctrl
    import line_buf_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter logic        FILL_VAL   = 1'b0,
    parameter bit          PREFILL_EN = 1'b1,
    parameter int unsigned UFL_CNT_W  = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 frame_start,
    input  logic                 pix_req,
    output logic                 fifo_rd_en,
    input  logic                 fifo_rd_data,
    input  logic                 fifo_rd_empty,
    input  logic                 fifo_almost_empty,
    output logic                 pix_out,
    output logic                 pix_valid,
    output logic                 pix_sol,
    output logic                 pix_eol,
    output logic                 pix_sof,
    output logic                 underflow,
    output logic [UFL_CNT_W-1:0] underflow_cnt,
    output logic                 busy
);

    localparam int unsigned HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

    rd_state_e     state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          served_q;
    logic          accept;
    logic          starved;
    logic          last_pix;

    // A request coinciding with frame_start is dropped: no read, no pixel.
    always_comb begin
        accept     = pix_req && !frame_start && (state != IDLE);
        fifo_rd_en = accept && (state == STREAM) && !fifo_rd_empty;
        starved    = accept && !fifo_rd_en;
        last_pix   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state         <= IDLE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            served_q      <= 1'b0;
            pix_valid     <= 1'b0;
            pix_sol       <= 1'b0;
            pix_eol       <= 1'b0;
            pix_sof       <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            pix_valid <= accept;
            served_q  <= fifo_rd_en;
            pix_sol   <= accept && (h_cnt == '0);
            pix_eol   <= accept && (h_cnt == H_LAST);
            pix_sof   <= accept && (h_cnt == '0) && (v_cnt == '0);

            if (frame_start) begin
                state         <= PREFILL;
                h_cnt         <= '0;
                v_cnt         <= '0;
                underflow     <= 1'b0;
                underflow_cnt <= '0;
            end else begin
                if (starved) begin
                    underflow <= 1'b1;
                    if (underflow_cnt != '1)
                        underflow_cnt <= underflow_cnt + UFL_CNT_W'(1);
                end

                if (accept) begin
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end

                if (accept && last_pix)
                    state <= IDLE;
                else if (state == PREFILL && (!PREFILL_EN || !fifo_almost_empty))
                    state <= STREAM;
            end
        end
    end

    // FIFO data has no output register, so only the served/fill select is pipelined.
    always_comb begin
        pix_out = 1'b0;
        if (pix_valid)
            pix_out = served_q ? fifo_rd_data : FILL_VAL;
    end

    always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_line_buf_1bit_rd_ctrl.sv
// Self-checking bench for line_buf_1bit_rd_ctrl: directed corner cases plus random
// traffic against a pixel-index reference model and a behavioural FIFO.
module tb_line_buf_1bit_rd_ctrl;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 2;
    localparam logic        FILL = 1'b1;
    localparam bit          PRE  = 1'b1;
    localparam int unsigned UW   = 2;
    localparam int          UMAX = (1 << UW) - 1;

    logic          rd_clk;
    logic          rd_rst;
    logic          frame_start;
    logic          pix_req;
    logic          fifo_rd_en;
    logic          fifo_rd_data;
    logic          fifo_rd_empty;
    logic          fifo_almost_empty;
    logic          pix_out;
    logic          pix_valid;
    logic          pix_sol;
    logic          pix_eol;
    logic          pix_sof;
    logic          underflow;
    logic [UW-1:0] underflow_cnt;
    logic          busy;

    line_buf_1bit_rd_ctrl #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FILL_VAL  (FILL),
        .PREFILL_EN(PRE),
        .UFL_CNT_W (UW)
    ) dut (
        .rd_clk           (rd_clk),
        .rd_rst           (rd_rst),
        .frame_start      (frame_start),
        .pix_req          (pix_req),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_empty    (fifo_rd_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .pix_out          (pix_out),
        .pix_valid        (pix_valid),
        .pix_sol          (pix_sol),
        .pix_eol          (pix_eol),
        .pix_sof          (pix_sof),
        .underflow        (underflow),
        .underflow_cnt    (underflow_cnt),
        .busy             (busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Behavioural FIFO: data appears one cycle after the read enable.
    bit fifo_mem [256];
    int wptr = 0;
    int rptr = 0;
    assign fifo_rd_empty = (wptr == rptr);
    initial fifo_rd_data = 1'b0;
    always @(posedge rd_clk) begin
        if (fifo_rd_en === 1'b1) begin
            fifo_rd_data <= fifo_mem[rptr % 256];
            rptr <= rptr + 1;
        end
    end

    task automatic push(input bit b);
        fifo_mem[wptr % 256] = b;
        wptr++;
    endtask

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position is a plain pixel index within H*V.
    int m_phase = 0;   // 0 idle, 1 waiting for fill level, 2 streaming
    int m_p     = 0;
    int m_ucnt  = 0;
    bit m_uf    = 0;
    int m_rptr  = 0;

    task automatic model_reset();
        m_phase = 0; m_p = 0; m_ucnt = 0; m_uf = 0;
    endtask

    task automatic cycle(input bit fs, input bit req, input bit ae);
        bit exp_rd, served, e_valid, e_pix, e_sol, e_eol, e_sof;
        frame_start = fs; pix_req = req; fifo_almost_empty = ae;
        #1;
        exp_rd = !fs && (m_phase == 2) && req && !fifo_rd_empty;
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        e_valid = 0; e_pix = 0; e_sol = 0; e_eol = 0; e_sof = 0;
        if (fs) begin
            m_phase = 1; m_p = 0; m_ucnt = 0; m_uf = 0;
        end else if (m_phase != 0) begin
            if (req) begin
                served  = (m_phase == 2) && !fifo_rd_empty;
                e_valid = 1;
                e_sol   = (m_p % H) == 0;
                e_eol   = (m_p % H) == H - 1;
                e_sof   = (m_p == 0);
                if (served) begin
                    e_pix = fifo_mem[m_rptr % 256];
                    m_rptr++;
                end else begin
                    e_pix = FILL;
                    m_uf  = 1;
                    if (m_ucnt < UMAX) m_ucnt++;
                end
                m_p++;
            end
            if (m_p == H * V) begin
                m_phase = 0; m_p = 0;
            end else if (m_phase == 1 && (!PRE || !ae)) begin
                m_phase = 2;
            end
        end
        @(posedge rd_clk);
        #1;
        chk("valid", {31'd0, pix_valid}, {31'd0, e_valid});
        if (e_valid) begin
            chk("pix", {31'd0, pix_out}, {31'd0, e_pix});
            chk("sol", {31'd0, pix_sol}, {31'd0, e_sol});
            chk("eol", {31'd0, pix_eol}, {31'd0, e_eol});
            chk("sof", {31'd0, pix_sof}, {31'd0, e_sof});
        end
        chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
        chk("ufl_cnt", {30'd0, underflow_cnt}, m_ucnt);
        chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
        @(negedge rd_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, pix_valid}, 0);
        chk({tag, "_pix"}, {31'd0, pix_out}, 0);
        chk({tag, "_sol"}, {31'd0, pix_sol}, 0);
        chk({tag, "_eol"}, {31'd0, pix_eol}, 0);
        chk({tag, "_sof"}, {31'd0, pix_sof}, 0);
        chk({tag, "_ufl"}, {31'd0, underflow}, 0);
        chk({tag, "_cnt"}, {30'd0, underflow_cnt}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_rden"}, {31'd0, fifo_rd_en}, 0);
    endtask

    // Asynchronous reset asserted between clock edges with a request pending.
    task automatic mid_reset();
        pix_req = 1'b1;
        #2 rd_rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        model_reset();
        @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    typedef struct {
        bit req;
        bit exp_valid;
        bit exp_pix;
        bit exp_sol;
        bit exp_eol;
        bit exp_sof;
    } vec_t;

    vec_t tbl [16];

    initial begin
        rd_rst = 1'b1; frame_start = 1'b0; pix_req = 1'b0; fifo_almost_empty = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tbl[i].req       = 1'b1;
            tbl[i].exp_valid = 1'b1;
            tbl[i].exp_pix   = (i % 2 == 0);
            tbl[i].exp_sol   = (i % 8 == 0);
            tbl[i].exp_eol   = (i % 8 == 7);
            tbl[i].exp_sof   = (i == 0);
        end
        repeat (2) @(negedge rd_clk);
        chk_all_zero("reset");
        rd_rst = 1'b0;

        // 1: full 8x2 frame from a preloaded FIFO
        for (int i = 0; i < 16; i++) push(i % 2 == 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, tbl[i].req, 0);
            chk("t1_valid", {31'd0, pix_valid}, {31'd0, tbl[i].exp_valid});
            chk("t1_pix", {31'd0, pix_out}, {31'd0, tbl[i].exp_pix});
            chk("t1_sol", {31'd0, pix_sol}, {31'd0, tbl[i].exp_sol});
            chk("t1_eol", {31'd0, pix_eol}, {31'd0, tbl[i].exp_eol});
            chk("t1_sof", {31'd0, pix_sof}, {31'd0, tbl[i].exp_sof});
        end
        chk("t1_busy_end", {31'd0, busy}, 0);

        // 2: FIFO runs dry after 5 pixels of a line
        for (int i = 0; i < 5; i++) push(i % 2 == 1);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0);
            if (i >= 5) chk("t2_fill", {31'd0, pix_out}, {31'd0, FILL});
        end
        chk("t2_ufl", {31'd0, underflow}, 1);
        chk("t2_cnt", {30'd0, underflow_cnt}, 3);

        // 3: almost_empty holds the controller in prefill
        push(1'b0);
        cycle(1, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, (i == 2 || i == 5 || i == 8), 1);
        chk("t3_cnt", {30'd0, underflow_cnt}, 3);
        cycle(0, 1, 0);
        chk("t3_still_prefill", {31'd0, pix_out}, {31'd0, FILL});
        cycle(0, 1, 0);
        chk("t3_stream_pix", {31'd0, pix_out}, 0);

        // 4: frame_start collides with a request at h_cnt=4
        push(1'b1); push(1'b0); push(1'b1);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        chk("t4_ufl_before", {31'd0, underflow}, 1);
        push(1'b0); push(1'b0);
        cycle(1, 1, 0);
        chk("t4_no_valid", {31'd0, pix_valid}, 0);
        chk("t4_ufl_clr", {31'd0, underflow}, 0);
        chk("t4_cnt_clr", {30'd0, underflow_cnt}, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("t4_sof", {31'd0, pix_sof}, 1);
        chk("t4_sol", {31'd0, pix_sol}, 1);

        // 5: reset mid-line
        cycle(0, 1, 0);
        chk("t5_valid_before", {31'd0, pix_valid}, 1);
        mid_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        chk("t5_no_valid", {31'd0, pix_valid}, 0);

        // 6: underflow counter saturation
        cycle(1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1);
            if (i == 2) chk("t6_cnt3", {30'd0, underflow_cnt}, 3);
        end
        chk("t6_sat", {30'd0, underflow_cnt}, 3);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int nb;
            nb = $urandom_range(0, 2);
            for (int k = 0; k < nb; k++)
                if (wptr - rptr < 200) push($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 399) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                      ($urandom_range(0, 7) == 0) || (wptr - rptr < 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
